mont_exp_sequencer: RTL and testbench

Control-only sequencer that runs left-to-right square-and-multiply modular exponentiation on one shared Montgomery multiplier. Each multiplication is issued through a start/done handshake. The block drives operand selects and write strobes for the operand registers, which sit outside this block in the datapath. It sits between the command FSM of the top-level wrapper and the exponentiation datapath, and replaces ad-hoc sequencing inside the exponentiation core.

---
 rtl/mont_exp_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_mont_exp_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mont_exp_sequencer.sv
// rtl/mont_exp_sequencer.sv - left-to-right square-and-multiply sequencer for one shared Montgomery multiplier
//
// Ports:
//   clk        clock, all state changes on its rising edge
//   resetn     asynchronous active-low reset
//   start      request a new exponentiation (sampled only in IDLE)
//   abort      synchronous abort back to IDLE, highest priority
//   exponent   exponent, captured when start is accepted
//   mul_start  one-cycle pulse launching one Montgomery multiplication
//   mul_done   one-cycle pulse from the multiplier, result valid
//   a_sel      operand A select: 0 = X, 1 = A register
//   b_sel      operand B select: 0 = R^2 mod m, 1 = A, 2 = X~, 3 = constant 1
//   a_init     load the A register with R mod m
//   a_we       write multiplier result into the A register
//   xt_we      write multiplier result into the X~ register
//   busy       high whenever not IDLE
//   done       one-cycle pulse, final result is in the A register
//   op_count   mul_start pulses issued in the current or last run (saturating)

module mont_exp_sequencer #(
  parameter int WIDTH = 512,
  parameter int OPC_W = 11
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] exponent,
  output logic             mul_start,
  input  logic             mul_done,
  output logic             a_sel,
  output logic [1:0]       b_sel,
  output logic             a_init,
  output logic             a_we,
  output logic             xt_we,
  output logic             busy,
  output logic             done,
  output logic [OPC_W-1:0] op_count
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    INIT_ISSUE = 4'd1,
    INIT_WAIT  = 4'd2,
    SQ_ISSUE   = 4'd3,
    SQ_WAIT    = 4'd4,
    MUL_ISSUE  = 4'd5,
    MUL_WAIT   = 4'd6,
    NEXT       = 4'd7,
    FIN_ISSUE  = 4'd8,
    FIN_WAIT   = 4'd9,
    DONE       = 4'd10
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [WIDTH-1:0]  exp_reg, exp_nxt;
  logic [OPC_W-1:0]  opc_reg, opc_nxt;
  logic [OPC_W-1:0]  opc_inc;

  // Saturating increment so a very long run never wraps back to a small count.
  assign opc_inc  = (&opc_reg) ? opc_reg : opc_reg + OPC_W'(1);
  assign op_count = opc_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      idx     <= '0;
      exp_reg <= '0;
      opc_reg <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      exp_reg <= exp_nxt;
      opc_reg <= opc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    exp_nxt   = exp_reg;
    opc_nxt   = opc_reg;
    mul_start = 1'b0;
    a_sel     = 1'b0;
    b_sel     = 2'd0;
    a_init    = 1'b0;
    a_we      = 1'b0;
    xt_we     = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);

    case (state)
      IDLE: begin
        if (start) begin
          // Gated by resetn so no output can rise while reset is held.
          a_init    = resetn;
          state_nxt = INIT_ISSUE;
          exp_nxt   = exponent;
          idx_nxt   = IDX_W'(WIDTH - 1);
          opc_nxt   = '0;
        end
      end
      INIT_ISSUE: begin
        mul_start = 1'b1;
        opc_nxt   = opc_inc;
        state_nxt = INIT_WAIT;
      end
      INIT_WAIT: begin
        if (mul_done) begin
          xt_we     = 1'b1;
          state_nxt = SQ_ISSUE;
        end
      end
      SQ_ISSUE: begin
        mul_start = 1'b1;
        a_sel     = 1'b1;
        b_sel     = 2'd1;
        opc_nxt   = opc_inc;
        state_nxt = SQ_WAIT;
      end
      SQ_WAIT: begin
        a_sel = 1'b1;
        b_sel = 2'd1;
        if (mul_done) begin
          a_we      = 1'b1;
          state_nxt = exp_reg[idx] ? MUL_ISSUE : NEXT;
        end
      end
      MUL_ISSUE: begin
        mul_start = 1'b1;
        a_sel     = 1'b1;
        b_sel     = 2'd2;
        opc_nxt   = opc_inc;
        state_nxt = MUL_WAIT;
      end
      MUL_WAIT: begin
        a_sel = 1'b1;
        b_sel = 2'd2;
        if (mul_done) begin
          a_we      = 1'b1;
          state_nxt = NEXT;
        end
      end
      NEXT: begin
        if (idx == '0) begin
          state_nxt = FIN_ISSUE;
        end else begin
          idx_nxt   = idx - IDX_W'(1);
          state_nxt = SQ_ISSUE;
        end
      end
      FIN_ISSUE: begin
        mul_start = 1'b1;
        a_sel     = 1'b1;
        b_sel     = 2'd3;
        opc_nxt   = opc_inc;
        state_nxt = FIN_WAIT;
      end
      FIN_WAIT: begin
        a_sel = 1'b1;
        b_sel = 2'd3;
        if (mul_done) begin
          a_we      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Abort wins over start and mul_done: no register update, no result
    // write and no completion pulse; op_count keeps its value.
    if (abort) begin
      state_nxt = IDLE;
      idx_nxt   = idx;
      exp_nxt   = exp_reg;
      opc_nxt   = opc_reg;
      a_init    = 1'b0;
      a_we      = 1'b0;
      xt_we     = 1'b0;
      done      = 1'b0;
    end
  end

endmodule

// File: tb/tb_mont_exp_sequencer.sv
// tb/tb_mont_exp_sequencer.sv - directed vector bench for mont_exp_sequencer (WIDTH=8)

module tb_mont_exp_sequencer;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        abort;
  logic [7:0]  exponent;
  logic        mul_start;
  logic        mul_done;
  logic        a_sel;
  logic [1:0]  b_sel;
  logic        a_init;
  logic        a_we;
  logic        xt_we;
  logic        busy;
  logic        done;
  logic [10:0] op_count;

  mont_exp_sequencer #(.WIDTH(8), .OPC_W(11)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .exponent(exponent), .mul_start(mul_start), .mul_done(mul_done),
    .a_sel(a_sel), .b_sel(b_sel), .a_init(a_init), .a_we(a_we),
    .xt_we(xt_we), .busy(busy), .done(done), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: mul_done rises lat_cfg cycles after the mul_start cycle.
  int lat_cfg = 3;
  int mcnt;
  always @(posedge clk or negedge resetn) begin
    if (!resetn)        mcnt <= 0;
    else if (mul_start) mcnt <= lat_cfg;
    else if (mcnt > 0)  mcnt <= mcnt - 1;
  end
  assign mul_done = (mcnt == 1);

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] e;
    int         lat;
    int         ops;
    int         done_cyc;
    int         awe;
  } vec_t;

  vec_t vecs[6];

  // One complete run; poke_cyc > 0 pulses start with another exponent mid-run.
  task automatic run_exp(input vec_t v, input int poke_cyc, input string tag);
    logic [1:0] exp_seq[$];
    int cyc, n_ops, n_awe, n_xwe, done_cyc, seq_bad, opc_at_done;
    exp_seq.delete();
    exp_seq.push_back(2'd0);
    for (int i = 7; i >= 0; i--) begin
      exp_seq.push_back(2'd1);
      if (v.e[i]) exp_seq.push_back(2'd2);
    end
    exp_seq.push_back(2'd3);

    lat_cfg = v.lat;
    @(posedge clk); #1;
    exponent = v.e;
    start    = 1'b1;
    @(negedge clk);
    chk({tag, ".a_init"}, a_init, 1);
    @(posedge clk); #1;
    start    = 1'b0;
    exponent = ~v.e;

    cyc = 0; n_ops = 0; n_awe = 0; n_xwe = 0; done_cyc = -1; seq_bad = 0; opc_at_done = -1;
    while (cyc < 400 && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      if (poke_cyc > 0 && cyc == poke_cyc) begin
        start    = 1'b1;
        exponent = 8'h0F;
      end else if (poke_cyc > 0 && cyc == poke_cyc + 1) begin
        start = 1'b0;
      end
      if (mul_start) begin
        if (n_ops >= exp_seq.size() || b_sel != exp_seq[n_ops] || a_sel != (n_ops != 0))
          seq_bad++;
        if (mul_done) seq_bad++;
        n_ops++;
      end
      if (a_we) begin
        n_awe++;
        if (b_sel == 2'd0) seq_bad++;
      end
      if (xt_we) begin
        n_xwe++;
        if (b_sel != 2'd0 || a_sel != 1'b0) seq_bad++;
      end
      if (done) begin
        done_cyc    = cyc;
        opc_at_done = int'(op_count);
      end
    end
    start = 1'b0;

    chk({tag, ".done_cycle"}, done_cyc, v.done_cyc);
    chk({tag, ".op_count"}, opc_at_done, v.ops);
    chk({tag, ".mul_starts"}, n_ops, v.ops);
    chk({tag, ".a_we_count"}, n_awe, v.awe);
    chk({tag, ".xt_we_count"}, n_xwe, 1);
    chk({tag, ".op_order_errors"}, seq_bad, 0);
    @(negedge clk);
    chk({tag, ".idle_after"}, {busy, done}, 0);
  endtask

  initial begin
    bit found;
    vecs[0] = '{e: 8'hB1, lat: 3, ops: 14, done_cyc: 65, awe: 13};
    vecs[1] = '{e: 8'h00, lat: 3, ops: 10, done_cyc: 49, awe: 9};
    vecs[2] = '{e: 8'hFF, lat: 1, ops: 18, done_cyc: 45, awe: 17};
    vecs[3] = '{e: 8'h01, lat: 2, ops: 11, done_cyc: 42, awe: 10};
    vecs[4] = '{e: 8'h80, lat: 1, ops: 11, done_cyc: 31, awe: 10};
    vecs[5] = '{e: 8'h5A, lat: 4, ops: 14, done_cyc: 79, awe: 13};

    resetn = 1'b0; start = 1'b0; abort = 1'b0; exponent = 8'h00;
    #12;
    chk("reset.outputs", {mul_start, a_sel, b_sel, a_init, a_we, xt_we, busy, done}, 0);
    chk("reset.op_count", op_count, 0);
    @(negedge clk);
    resetn = 1'b1;

    // start together with abort in IDLE must not be accepted
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; exponent = 8'hB1;
    @(negedge clk);
    chk("start_abort.a_init", a_init, 0);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort.busy", busy, 0);

    for (int i = 0; i < 6; i++)
      run_exp(vecs[i], 0, $sformatf("vec%0d", i));

    // start pulsed mid-run with a different exponent changes nothing
    run_exp(vecs[0], 20, "midstart");

    // abort coinciding with mul_done in MUL_WAIT
    lat_cfg = 3;
    @(posedge clk); #1;
    exponent = 8'hB1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (busy && b_sel == 2'd2 && !mul_start && mul_done) found = 1'b1;
    end
    chk("abort.reached_mul_wait", found, 1);
    abort = 1'b1;
    #1;
    chk("abort.a_we", a_we, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.op_count_held", op_count, 3);
    @(negedge clk);
    chk("abort.no_done", done, 0);
    run_exp(vecs[0], 0, "after_abort");

    // asynchronous reset during SQ_WAIT
    lat_cfg = 3;
    @(posedge clk); #1;
    exponent = 8'hB1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (busy && b_sel == 2'd1 && !mul_start) found = 1'b1;
    end
    chk("reset_mid.reached_sq_wait", found, 1);
    resetn = 1'b0;
    #1;
    chk("reset_mid.outputs", {mul_start, a_sel, b_sel, a_init, a_we, xt_we, busy, done}, 0);
    chk("reset_mid.op_count", op_count, 0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    run_exp(vecs[0], 0, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
